// File: rtl/sd_route_pkg.sv
// Shared types and constants for the SD SPI route controller.
// The state enum is 2 bits wide; the park levels define an idle, deselected card interface.
package sd_route_pkg;

  typedef enum logic [1:0] {
    ST_ROUTE_PHY = 2'd0,
    ST_ROUTE_VSD = 2'd1,
    ST_GUARD     = 2'd2,
    ST_PARK      = 2'd3
  } route_state_e;

  localparam logic PARK_SCK  = 1'b0;
  localparam logic PARK_MOSI = 1'b1;
  localparam logic PARK_SS_N = 1'b1;

endpackage

// File: rtl/sd_act_timer.sv
// SD activity detector: a change on mosi or the routed miso keeps o_act high
// for ACT_TIMEOUT cycles after the last change.
module sd_act_timer #(
  parameter int ACT_TIMEOUT = 1000000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic i_mosi,
  input  logic i_miso,
  output logic o_act
);

  localparam int AW = $clog2(ACT_TIMEOUT + 1);
  localparam logic [AW-1:0] RELOAD = AW'(ACT_TIMEOUT - 1);

  logic          r_mosi_d;
  logic          r_miso_d;
  logic [AW-1:0] r_cnt;
  logic          r_act;
  logic          w_toggle;

  assign w_toggle = (i_mosi != r_mosi_d) || (i_miso != r_miso_d);
  assign o_act    = r_act;

  // The delayed copies also track during reset, so leaving reset never looks like a toggle.
  always_ff @(posedge clk_sys) begin
    r_mosi_d <= i_mosi;
    r_miso_d <= i_miso;
    if (reset) begin
      r_cnt <= '0;
      r_act <= 1'b0;
    end else if (w_toggle) begin
      r_cnt <= RELOAD;
      r_act <= 1'b1;
    end else begin
      r_act <= (r_cnt != '0);
      if (r_cnt != '0) r_cnt <= r_cnt - AW'(1);
    end
  end

endmodule

// File: rtl/sd_route_ctrl.sv
// Owner of the shared SD SPI port: routes the core's SPI master to the physical pins or to the
// virtual card. It switches only at a bus-idle point, and drives the activity LED and the mount reset pulse.
module sd_route_ctrl
  import sd_route_pkg::*;
#(
  parameter int GUARD_CYCLES = 16,
  parameter int GAP_CYCLES   = 8,
  parameter int ACT_TIMEOUT  = 1000000,
  parameter int RST_LEN      = 256
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic img_mounted,
  input  logic img_size_nz,
  input  logic rst_after_mount,
  input  logic spi_sck,
  input  logic spi_mosi,
  input  logic spi_ss_n,
  output logic spi_miso,
  output logic vsd_sck,
  output logic vsd_mosi,
  output logic vsd_ss_n,
  input  logic vsd_miso,
  output logic phy_sck,
  output logic phy_mosi,
  output logic phy_ss_n,
  input  logic phy_miso,
  output logic vsd_sel,
  output logic sd_act,
  output logic mount_rst
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int PW = $clog2(GAP_CYCLES + 1);
  localparam int RW = $clog2(RST_LEN + 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
  localparam logic [PW-1:0] PARK_LAST  = PW'(GAP_CYCLES - 1);
  localparam logic [RW-1:0] RST_RELOAD = RW'(RST_LEN - 1);

  route_state_e  r_state;
  route_state_e  w_state_next;
  logic [GW-1:0] r_guard_cnt;
  logic [PW-1:0] r_park_cnt;
  logic [RW-1:0] r_rst_cnt;
  logic          r_miso_meta, r_miso_sync;
  logic          r_mnt_d, r_target, r_vsd_sel, r_mount_rst;
  logic          w_mount_ev, w_target_next, w_phy_on, w_vsd_on, w_miso;

  assign w_mount_ev    = img_mounted && !r_mnt_d;
  assign w_target_next = w_mount_ev ? img_size_nz : r_target;
  assign vsd_sel       = r_vsd_sel;
  assign mount_rst     = r_mount_rst;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_miso_meta <= 1'b1;
      r_miso_sync <= 1'b1;
    end else begin
      r_miso_meta <= phy_miso;
      r_miso_sync <= r_miso_meta;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state     <= ST_ROUTE_PHY;
      r_guard_cnt <= '0;
      r_park_cnt  <= '0;
      r_target    <= 1'b0;
      r_mnt_d     <= 1'b0;
      r_vsd_sel   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_target    <= w_target_next;
      r_mnt_d     <= img_mounted;
      r_guard_cnt <= (r_state == ST_GUARD && w_state_next == ST_GUARD && spi_ss_n)
                     ? r_guard_cnt + GW'(1) : '0;
      r_park_cnt  <= (r_state == ST_PARK && w_state_next == ST_PARK)
                     ? r_park_cnt + PW'(1) : '0;
      if (r_state == ST_PARK && w_state_next != ST_PARK) r_vsd_sel <= w_target_next;
    end
  end

  // The newest target (including a mount seen this cycle) drives every decision.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_ROUTE_PHY, ST_ROUTE_VSD: begin
        if (w_target_next != r_vsd_sel) w_state_next = ST_GUARD;
      end
      ST_GUARD: begin
        if (w_target_next == r_vsd_sel)
          w_state_next = r_vsd_sel ? ST_ROUTE_VSD : ST_ROUTE_PHY;
        else if (spi_ss_n && r_guard_cnt == GUARD_LAST)
          w_state_next = ST_PARK;
      end
      ST_PARK: begin
        if (r_park_cnt == PARK_LAST)
          w_state_next = w_target_next ? ST_ROUTE_VSD : ST_ROUTE_PHY;
      end
      default: w_state_next = ST_ROUTE_PHY;
    endcase
  end

  always_comb begin
    w_phy_on = (r_state != ST_PARK) && !r_vsd_sel;
    w_vsd_on = (r_state != ST_PARK) && r_vsd_sel;
    phy_sck  = w_phy_on ? spi_sck  : PARK_SCK;
    phy_mosi = w_phy_on ? spi_mosi : PARK_MOSI;
    phy_ss_n = w_phy_on ? spi_ss_n : PARK_SS_N;
    vsd_sck  = w_vsd_on ? spi_sck  : PARK_SCK;
    vsd_mosi = w_vsd_on ? spi_mosi : PARK_MOSI;
    vsd_ss_n = w_vsd_on ? spi_ss_n : PARK_SS_N;
    if (r_state == ST_PARK) w_miso = 1'b1;
    else if (r_vsd_sel)     w_miso = vsd_miso;
    else                    w_miso = r_miso_sync;
    spi_miso = w_miso;
  end

  // A qualifying mount during a running pulse restarts the full length.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_rst_cnt   <= '0;
      r_mount_rst <= 1'b0;
    end else if (w_mount_ev && rst_after_mount) begin
      r_rst_cnt   <= RST_RELOAD;
      r_mount_rst <= 1'b1;
    end else begin
      r_mount_rst <= (r_rst_cnt != '0);
      if (r_rst_cnt != '0) r_rst_cnt <= r_rst_cnt - RW'(1);
    end
  end

  sd_act_timer #(
    .ACT_TIMEOUT(ACT_TIMEOUT)
  ) u_act_timer (
    .clk_sys(clk_sys),
    .reset  (reset),
    .i_mosi (spi_mosi),
    .i_miso (w_miso),
    .o_act  (sd_act)
  );

endmodule
